// File: rtl/cpu_0_nios2_oci_dct_packer_pkg.sv
// Shared constants for the OCI direct-trace path: atom geometry, atom codes
// and the layout of the packed output word.
package cpu_0_nios2_oci_trace_pkg;

  localparam int ATOM_W = 2;
  localparam int ATOMS  = 15;
  localparam int BUF_W  = ATOM_W * ATOMS;
  localparam int CNT_W  = 4;
  localparam int OUT_W  = CNT_W + BUF_W;

  localparam logic [ATOM_W-1:0] ATOM_NOP    = 2'b00;
  localparam logic [ATOM_W-1:0] ATOM_TAKEN  = 2'b01;
  localparam logic [ATOM_W-1:0] ATOM_NTAKEN = 2'b10;
  localparam logic [ATOM_W-1:0] ATOM_ADDR   = 2'b11;

  // out_data field offsets: count sits above the atom buffer
  localparam int OD_BUF_LSB = 0;
  localparam int OD_CNT_LSB = BUF_W;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [BUF_W-1:0] atoms;
  } out_word_t;

endpackage

// File: rtl/cpu_0_nios2_oci_dct_packer_if.sv
// Atom input, output word handshake and live debug view of the packer.
// master = trace controller / FIFO side, slave = packer.
interface cpu_0_nios2_oci_dct_packer_if;
  import cpu_0_nios2_oci_trace_pkg::*;

  logic              atom_valid;
  logic [ATOM_W-1:0] atom;
  logic              atom_ready;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic [BUF_W-1:0]  dct_buffer;
  logic [CNT_W-1:0]  dct_count;
  logic              ovf;
  logic              ovf_clr;

  modport master (
    output atom_valid, atom, flush, out_ready, ovf_clr,
    input  atom_ready, out_valid, out_data, dct_buffer, dct_count, ovf
  );

  modport slave (
    input  atom_valid, atom, flush, out_ready, ovf_clr,
    output atom_ready, out_valid, out_data, dct_buffer, dct_count, ovf
  );

endinterface

// File: rtl/cpu_0_nios2_oci_dct_outreg.sv
// One-entry valid/ready output register; loads on i_load, 1 edge latency.
// Holds word while o_vld && !i_rdy; the caller only loads when the slot is free.
module cpu_0_nios2_oci_dct_outreg
  import cpu_0_nios2_oci_trace_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [OUT_W-1:0] i_dat,
  input  logic             i_rdy,
  output logic             o_vld,
  output logic [OUT_W-1:0] o_dat
);

  logic             r_vld;
  logic [OUT_W-1:0] r_dat;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= 1'b0;
      r_dat <= '0;
    end else if (i_load) begin
      r_vld <= 1'b1;
      r_dat <= i_dat;
    end else if (i_rdy) begin
      r_vld <= 1'b0;
    end
  end

  assign o_vld = r_vld;
  assign o_dat = r_dat;

endmodule

// File: rtl/cpu_0_nios2_oci_dct_packer.sv
// Packs 2-bit trace atoms into 15-atom words; word leaves 1 edge after count
// hits 15 or a flush. Stalls atoms (atom_ready=0) when full and the output is held.
module cpu_0_nios2_oci_dct_packer
  import cpu_0_nios2_oci_trace_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset_n,
  cpu_0_nios2_oci_dct_packer_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ATOMS);

  logic [BUF_W-1:0] r_buf;
  logic [CNT_W-1:0] r_count;
  logic             r_flush_pend;
  logic             r_ovf;

  logic             w_out_vld;
  logic [OUT_W-1:0] w_out_dat;
  logic             w_atom_ready;
  logic             w_accept;
  logic             w_slot_free;
  logic             w_fpend;
  logic             w_xfer;
  out_word_t        w_word;

  assign w_atom_ready = (r_count != CNT_FULL);
  assign w_accept     = bus.atom_valid && w_atom_ready;
  assign w_slot_free  = !w_out_vld || bus.out_ready;
  assign w_fpend      = r_flush_pend || bus.flush;
  assign w_xfer       = w_slot_free &&
                        ((r_count == CNT_FULL) || (w_fpend && (r_count != '0)));
  assign w_word       = '{cnt: r_count, atoms: r_buf};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_buf        <= '0;
      r_count      <= '0;
      r_flush_pend <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      // An atom accepted alongside a transfer starts the next word
      if (w_xfer) begin
        r_buf   <= w_accept ? {{(BUF_W-ATOM_W){1'b0}}, bus.atom} : '0;
        r_count <= w_accept ? CNT_W'(1) : '0;
      end else if (w_accept) begin
        r_buf   <= {r_buf[BUF_W-ATOM_W-1:0], bus.atom};
        r_count <= r_count + CNT_W'(1);
      end

      if (w_xfer)
        r_flush_pend <= 1'b0;
      else if (bus.flush && (r_count == '0) && !w_accept)
        r_flush_pend <= 1'b0;
      else if (bus.flush)
        r_flush_pend <= 1'b1;

      if (bus.atom_valid && !w_atom_ready)
        r_ovf <= 1'b1;
      else if (bus.ovf_clr)
        r_ovf <= 1'b0;
    end
  end

  cpu_0_nios2_oci_dct_outreg u_outreg (
    .clk    (clk),
    .rst_n  (reset_n),
    .i_load (w_xfer),
    .i_dat  (w_word),
    .i_rdy  (bus.out_ready),
    .o_vld  (w_out_vld),
    .o_dat  (w_out_dat)
  );

  assign bus.atom_ready = w_atom_ready;
  assign bus.out_valid  = w_out_vld;
  assign bus.out_data   = w_out_dat;
  assign bus.dct_buffer = r_buf;
  assign bus.dct_count  = r_count;
  assign bus.ovf        = r_ovf;

endmodule

// File: tb/tb_cpu_0_nios2_oci_dct_packer.sv
// Directed test of the trace atom packer with hand-computed expected words.
module tb_cpu_0_nios2_oci_dct_packer;
  import cpu_0_nios2_oci_trace_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  cpu_0_nios2_oci_dct_packer_if bus ();

  cpu_0_nios2_oci_dct_packer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_n(input int n, input logic [1:0] a);
    for (int i = 0; i < n; i++) begin
      bus.atom_valid = 1'b1;
      bus.atom       = a;
      tick();
    end
    bus.atom_valid = 1'b0;
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.atom_valid = 1'b0;
    bus.atom       = ATOM_NOP;
    bus.flush      = 1'b0;
    bus.out_ready  = 1'b0;
    bus.ovf_clr    = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_data",  64'(bus.out_data), 64'(0));
    chk("rst_count",     64'(bus.dct_count), 64'(0));
    chk("rst_buffer",    64'(bus.dct_buffer), 64'(0));
    chk("rst_ovf",       64'(bus.ovf), 64'(0));
    chk("rst_atom_ready", 64'(bus.atom_ready), 64'(1));
    reset_n = 1'b1;

    // 1: full word of TAKEN atoms, output free
    bus.out_ready = 1'b1;
    push_n(15, ATOM_TAKEN);
    chk("t1_atom_ready_full", 64'(bus.atom_ready), 64'(0));
    chk("t1_count_15",        64'(bus.dct_count), 64'(15));
    chk("t1_no_valid_yet",    64'(bus.out_valid), 64'(0));
    tick();
    chk("t1_out_valid", 64'(bus.out_valid), 64'(1));
    chk("t1_out_data",  64'(bus.out_data), 64'({4'hF, 30'h15555555}));
    chk("t1_count_0",   64'(bus.dct_count), 64'(0));
    tick();
    chk("t1_valid_drop", 64'(bus.out_valid), 64'(0));

    // 2: partial word via flush, then flush with empty buffer
    push_n(1, ATOM_ADDR);
    push_n(1, ATOM_NTAKEN);
    push_n(1, ATOM_TAKEN);
    chk("t2_count_3",  64'(bus.dct_count), 64'(3));
    chk("t2_buffer",   64'(bus.dct_buffer), 64'(30'h39));
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("t2_out_valid", 64'(bus.out_valid), 64'(1));
    chk("t2_out_data",  64'(bus.out_data), 64'({4'h3, 30'h00000039}));
    chk("t2_count_0",   64'(bus.dct_count), 64'(0));
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("t2_empty_flush_valid", 64'(bus.out_valid), 64'(0));
    tick();
    chk("t2_empty_flush_valid2", 64'(bus.out_valid), 64'(0));
    chk("t2_empty_flush_count",  64'(bus.dct_count), 64'(0));

    // 3: full stall with output held, overflow, then release
    bus.out_ready = 1'b0;
    push_n(15, ATOM_NTAKEN);
    tick();
    chk("t3_first_valid", 64'(bus.out_valid), 64'(1));
    chk("t3_first_data",  64'(bus.out_data), 64'({4'hF, 30'h2AAAAAAA}));
    push_n(15, ATOM_ADDR);
    chk("t3_stall_ready", 64'(bus.atom_ready), 64'(0));
    chk("t3_stall_count", 64'(bus.dct_count), 64'(15));
    chk("t3_no_ovf_yet",  64'(bus.ovf), 64'(0));
    push_n(2, ATOM_TAKEN);
    chk("t3_ovf_set",      64'(bus.ovf), 64'(1));
    chk("t3_count_held",   64'(bus.dct_count), 64'(15));
    chk("t3_buffer_held",  64'(bus.dct_buffer), 64'(30'h3FFFFFFF));
    chk("t3_data_held",    64'(bus.out_data), 64'({4'hF, 30'h2AAAAAAA}));
    chk("t3_valid_held",   64'(bus.out_valid), 64'(1));
    bus.out_ready = 1'b1;
    tick();
    chk("t3_release_valid", 64'(bus.out_valid), 64'(1));
    chk("t3_release_data",  64'(bus.out_data), 64'({4'hF, 30'h3FFFFFFF}));
    chk("t3_release_count", 64'(bus.dct_count), 64'(0));
    chk("t3_ovf_sticky",    64'(bus.ovf), 64'(1));
    tick();
    chk("t3_valid_drop", 64'(bus.out_valid), 64'(0));
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    chk("t3_ovf_clr", 64'(bus.ovf), 64'(0));

    // 4: atom accepted in the transfer cycle starts the next word
    push_n(3, ATOM_TAKEN);
    bus.flush      = 1'b1;
    bus.atom_valid = 1'b1;
    bus.atom       = ATOM_NTAKEN;
    tick();
    bus.flush      = 1'b0;
    bus.atom_valid = 1'b0;
    chk("t4_out_data", 64'(bus.out_data), 64'({4'h3, 30'h00000015}));
    chk("t4_count_1",  64'(bus.dct_count), 64'(1));
    chk("t4_buffer",   64'(bus.dct_buffer), 64'(30'h2));
    tick();
    chk("t4_no_reemit", 64'(bus.out_valid), 64'(0));
    chk("t4_count_kept", 64'(bus.dct_count), 64'(1));

    // 5: reset mid-word with output held and a flush pending
    bus.out_ready = 1'b0;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("t5_held_data", 64'(bus.out_data), 64'({4'h1, 30'h2}));
    push_n(7, ATOM_TAKEN);
    chk("t5_count_7",  64'(bus.dct_count), 64'(7));
    chk("t5_buffer",   64'(bus.dct_buffer), 64'(30'h1555));
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("t5_rst_valid",  64'(bus.out_valid), 64'(0));
    chk("t5_rst_data",   64'(bus.out_data), 64'(0));
    chk("t5_rst_count",  64'(bus.dct_count), 64'(0));
    chk("t5_rst_buffer", 64'(bus.dct_buffer), 64'(0));
    chk("t5_rst_ovf",    64'(bus.ovf), 64'(0));
    bus.out_ready = 1'b1;
    push_n(1, ATOM_TAKEN);
    tick();
    chk("t5_no_emit",     64'(bus.out_valid), 64'(0));
    chk("t5_count_after", 64'(bus.dct_count), 64'(1));

    // 6: overflow and ovf_clr in the same cycle, set wins
    bus.out_ready = 1'b0;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("t6_held_data", 64'(bus.out_data), 64'({4'h1, 30'h1}));
    push_n(15, ATOM_NOP);
    chk("t6_count_15", 64'(bus.dct_count), 64'(15));
    bus.atom_valid = 1'b1;
    bus.ovf_clr    = 1'b1;
    tick();
    bus.atom_valid = 1'b0;
    chk("t6_set_wins", 64'(bus.ovf), 64'(1));
    tick();
    bus.ovf_clr = 1'b0;
    chk("t6_clr_alone", 64'(bus.ovf), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
